cart_packetizer: RTL

Buffers captured N64 cartridge bus transactions (32-bit address + 32-bit data pairs, one-cycle valid pulse, no backpressure) in a FIFO and serializes each one into a fixed 10-byte framed packet on an 8-bit valid/ready byte stream toward the Raspberry Pi host link. Sits directly downstream of the cartridge capture stage. Absorbs bursts and reports dropped transactions when the host side stalls.

---
 rtl/cart_pkg.sv | 44 ++++
 rtl/cart_packetizer_if.sv | 21 ++
 rtl/cart_xact_fifo.sv | 72 +++++++
 rtl/cart_packetizer.sv | 129 ++++++++++++
 4 files changed

// File: rtl/cart_pkg.sv
// Shared types for the N64 cartridge capture path: transaction struct,
// packet geometry and the byte-selection/checksum helpers.
package cart_pkg;

  localparam int PKT_LEN = 10;
  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;
  localparam int IDX_W = 4;

  typedef logic [IDX_W-1:0] idx_t;
  localparam idx_t LAST_IDX = idx_t'(PKT_LEN - 1);

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } cart_xact_t;

  typedef enum logic {
    ST_IDLE,
    ST_SEND
  } pkt_state_t;

  // Payload bytes 1..8 of a packet, address first, most significant byte first.
  function automatic logic [7:0] xact_byte(cart_xact_t x, idx_t idx);
    logic [7:0] b;
    case (idx)
      4'd1:    b = x.addr[31:24];
      4'd2:    b = x.addr[23:16];
      4'd3:    b = x.addr[15:8];
      4'd4:    b = x.addr[7:0];
      4'd5:    b = x.data[31:24];
      4'd6:    b = x.data[23:16];
      4'd7:    b = x.data[15:8];
      4'd8:    b = x.data[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  function automatic logic [7:0] xact_csum(cart_xact_t x);
    return x.addr[31:24] ^ x.addr[23:16] ^ x.addr[15:8] ^ x.addr[7:0] ^
           x.data[31:24] ^ x.data[23:16] ^ x.data[15:8] ^ x.data[7:0];
  endfunction

endpackage

// File: rtl/cart_packetizer_if.sv
// Capture strobe input and host-side byte stream of the packetizer.
interface cart_packetizer_if;
  // cap_*: one-cycle strobe, never stalled. tx_*: a byte moves on every rising
  // edge where tx_valid & tx_ready; once raised, tx_valid/tx_data hold until taken.
  logic [31:0] cap_addr;
  logic [31:0] cap_data;
  logic        cap_valid;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  modport slave (
    input  cap_addr, cap_data, cap_valid, tx_ready,
    output tx_data, tx_valid
  );

  modport master (
    output cap_addr, cap_data, cap_valid, tx_ready,
    input  tx_data, tx_valid
  );
endinterface

// File: rtl/cart_xact_fifo.sv
// Transaction FIFO with a registered head word, so the reader sees the oldest
// entry straight from a flop and can pop and push in the same cycle.
module cart_xact_fifo
  import cart_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  cart_xact_t             wdata_i,
  input  logic                   pop_i,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] level_o,
  output cart_xact_t             head_o
);
  localparam int AW = $clog2(DEPTH);
  typedef logic [AW-1:0] ptr_t;
  typedef logic [AW:0]   lvl_t;

  cart_xact_t mem_q [DEPTH];
  ptr_t       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  lvl_t       level_q, level_d;
  cart_xact_t head_q, head_d;

  always_comb begin
    wr_ptr_d = push_i ? wr_ptr_q + ptr_t'(1) : wr_ptr_q;
    rd_ptr_d = pop_i ? rd_ptr_q + ptr_t'(1) : rd_ptr_q;
    level_d  = level_q;
    case ({push_i, pop_i})
      2'b10:   level_d = level_q + lvl_t'(1);
      2'b01:   level_d = level_q - lvl_t'(1);
      default: level_d = level_q;
    endcase
    // Head follows the next entry; a push into an emptying FIFO bypasses memory.
    head_d = head_q;
    if (pop_i) begin
      if (level_q == lvl_t'(1)) begin
        if (push_i) head_d = wdata_i;
      end else begin
        head_d = mem_q[rd_ptr_d];
      end
    end else if (level_q == '0 && push_i) begin
      head_d = wdata_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      head_q   <= head_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign full_o  = (level_q == lvl_t'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign head_o  = head_q;

endmodule

// File: rtl/cart_packetizer.sv
// Buffers captured cartridge transactions and streams each one to the host as
// a 10-byte packet: sync, address, data, XOR checksum.
module cart_packetizer
  import cart_pkg::*;
#(
  parameter int         FIFO_DEPTH = 16,
  parameter logic [7:0] SYNC_BYTE  = SYNC_DEFAULT
) (
  input  logic                        clk,
  input  logic                        reset,
  cart_packetizer_if.slave            bus,
  input  logic                        clr_stats,
  output logic                        overflow,
  output logic [15:0]                 drop_cnt,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output pkt_state_t                  dbg_state
);
  pkt_state_t state_q, state_d;
  idx_t       idx_q, idx_d, idx_nxt;
  cart_xact_t pkt_q, pkt_d, fifo_head, cap_xact;
  logic [7:0] csum_q, csum_d, tx_data_q, tx_data_d;
  logic       tx_valid_q, tx_valid_d;
  logic       overflow_q, overflow_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;
  logic       push, pop, drop, hs, fifo_full, fifo_empty;

  assign cap_xact = cart_xact_t'{addr: bus.cap_addr, data: bus.cap_data};

  cart_xact_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .push_i  (push),
    .wdata_i (cap_xact),
    .pop_i   (pop),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level),
    .head_o  (fifo_head)
  );

  assign hs      = tx_valid_q && bus.tx_ready;
  assign idx_nxt = idx_q + idx_t'(1);

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    pkt_d      = pkt_q;
    csum_d     = csum_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    pop        = 1'b0;
    case (state_q)
      ST_IDLE: pop = !fifo_empty;
      ST_SEND: begin
        if (hs) begin
          if (idx_q == LAST_IDX) begin
            if (!fifo_empty) begin
              pop = 1'b1;
            end else begin
              state_d    = ST_IDLE;
              idx_d      = '0;
              tx_valid_d = 1'b0;
              tx_data_d  = 8'h00;
            end
          end else begin
            idx_d     = idx_nxt;
            tx_data_d = (idx_nxt == LAST_IDX) ? csum_q : xact_byte(pkt_q, idx_nxt);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Loading the next packet presents its sync byte on the following cycle.
    if (pop) begin
      state_d    = ST_SEND;
      idx_d      = '0;
      pkt_d      = fifo_head;
      csum_d     = xact_csum(fifo_head);
      tx_data_d  = SYNC_BYTE;
      tx_valid_d = 1'b1;
    end
  end

  // A pop frees a slot in the same cycle, so a full FIFO still accepts then.
  assign push = bus.cap_valid && (!fifo_full || pop);
  assign drop = bus.cap_valid && !push;

  always_comb begin
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (drop) begin
      overflow_d = 1'b1;
      if (clr_stats)                  drop_cnt_d = 16'd1;
      else if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
    end else if (clr_stats) begin
      overflow_d = 1'b0;
      drop_cnt_d = 16'd0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      pkt_q      <= '0;
      csum_q     <= 8'h00;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      overflow_q <= 1'b0;
      drop_cnt_q <= 16'd0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      pkt_q      <= pkt_d;
      csum_q     <= csum_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign bus.tx_data  = tx_data_q;
  assign bus.tx_valid = tx_valid_q;
  assign overflow     = overflow_q;
  assign drop_cnt     = drop_cnt_q;
  assign dbg_state    = state_q;

endmodule
